// File: rtl/fetch_redirect_if.sv
// Fetch front-end bundle: instruction-memory port, decode handshake and branch redirect.
// The master side is the fetch unit; the slave side is its surroundings (memory, decode, branch unit).
interface fetch_redirect_if #(
    parameter int XLEN = 32
);
    logic            i_DoBranch;
    logic [XLEN-1:0] i_BrTarget;
    logic            o_IReq;
    logic [XLEN-1:0] o_IAddr;
    logic            i_IAck;
    logic [XLEN-1:0] i_IData;
    logic            o_Valid;
    logic [XLEN-1:0] o_Instr;
    logic [XLEN-1:0] o_PC;
    logic            i_Ready;
    logic            o_Misalign;

    modport master (
        input  i_DoBranch, i_BrTarget, i_IAck, i_IData, i_Ready,
        output o_IReq, o_IAddr, o_Valid, o_Instr, o_PC, o_Misalign
    );

    modport slave (
        output i_DoBranch, i_BrTarget, i_IAck, i_IData, i_Ready,
        input  o_IReq, o_IAddr, o_Valid, o_Instr, o_PC, o_Misalign
    );
endinterface

// File: rtl/fetch_redirect.sv
// Single-outstanding instruction fetch unit with branch redirect and wrong-path squash.
// Alternates FETCH (request in flight) and OUT (instruction held for decode).
module fetch_redirect #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    fetch_redirect_if.master bus
);
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] OUT   = 1'b1;

    logic [0:0]      state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            pending_reg, pending_next;
    logic [XLEN-1:0] tgt_reg, tgt_next;
    logic            valid_reg, valid_next;
    logic [XLEN-1:0] instr_reg, instr_next;
    logic [XLEN-1:0] opc_reg, opc_next;
    logic            ireq_reg, ireq_next;
    logic            misalign_reg, misalign_next;

    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] redirect_tgt;

    // Redirect targets are always word aligned; a fresh branch beats the latched one.
    assign br_tgt       = {bus.i_BrTarget[XLEN-1:2], 2'b00};
    assign redirect_tgt = bus.i_DoBranch ? br_tgt : tgt_reg;

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pending_next = pending_reg;
        tgt_next     = tgt_reg;
        valid_next   = valid_reg;
        instr_next   = instr_reg;
        opc_next     = opc_reg;
        case (state_reg)
            FETCH: begin
                // An ack arriving in the first cycle after reset is taken as the answer
                // to the request for pc, even though o_IReq is not yet high.
                if (bus.i_IAck) begin
                    if (bus.i_DoBranch || pending_reg) begin
                        pc_next      = redirect_tgt;
                        pending_next = 1'b0;
                    end else begin
                        instr_next = bus.i_IData;
                        opc_next   = pc_reg;
                        pc_next    = pc_reg + XLEN'(4);
                        valid_next = 1'b1;
                        state_next = OUT;
                    end
                end else if (bus.i_DoBranch) begin
                    pending_next = 1'b1;
                    tgt_next     = br_tgt;
                end
            end
            OUT: begin
                if (bus.i_DoBranch) begin
                    valid_next = 1'b0;
                    pc_next    = br_tgt;
                    state_next = FETCH;
                end else if (bus.i_Ready) begin
                    valid_next = 1'b0;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
        ireq_next     = (state_next == FETCH);
        misalign_next = bus.i_DoBranch && (bus.i_BrTarget[1:0] != 2'b00);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            pending_reg  <= 1'b0;
            tgt_reg      <= '0;
            valid_reg    <= 1'b0;
            instr_reg    <= '0;
            opc_reg      <= '0;
            ireq_reg     <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pending_reg  <= pending_next;
            tgt_reg      <= tgt_next;
            valid_reg    <= valid_next;
            instr_reg    <= instr_next;
            opc_reg      <= opc_next;
            ireq_reg     <= ireq_next;
            misalign_reg <= misalign_next;
        end
    end

    assign bus.o_IReq     = ireq_reg;
    assign bus.o_IAddr    = pc_reg;
    assign bus.o_Valid    = valid_reg;
    assign bus.o_Instr    = instr_reg;
    assign bus.o_PC       = opc_reg;
    assign bus.o_Misalign = misalign_reg;
endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: memory model with adjustable ack delay,
// scoreboard of expected {pc, instr} pairs, and a log of acknowledged fetch addresses.
module tb_fetch_redirect;
    logic clk;
    logic rst_n;

    fetch_redirect_if #(.XLEN(32)) bus ();

    fetch_redirect #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .i_clk (clk),
        .i_rstn(rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb[$];
    logic [31:0] ack_log[$];
    logic [31:0] exp_acks[$];
    bit          mem_on   = 1'b0;
    int          ack_wait = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!bus.o_Valid && k < 40) begin
            step();
            k++;
        end
        check(tag, {31'b0, bus.o_Valid}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            step();
            k++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_acks(input string tag);
        check({tag, "_count"}, 32'(ack_log.size()), 32'(exp_acks.size()));
        for (int i = 0; i < exp_acks.size() && i < ack_log.size(); i++)
            check({tag, "_addr"}, ack_log[i], exp_acks[i]);
        ack_log.delete();
    endtask

    task automatic push_exp(input logic [31:0] pc);
        sb.push_back({pc, imem(pc)});
    endtask

    // Memory: acknowledges a request after ack_wait cycles of o_IReq.
    initial begin
        int wcnt;
        wcnt        = 0;
        bus.i_IAck  = 1'b0;
        bus.i_IData = '0;
        forever begin
            @(negedge clk);
            if (mem_on && bus.o_IReq) begin
                if (wcnt >= ack_wait) begin
                    bus.i_IAck  = 1'b1;
                    bus.i_IData = imem(bus.o_IAddr);
                    ack_log.push_back(bus.o_IAddr);
                    wcnt        = 0;
                end else begin
                    bus.i_IAck = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.i_IAck = 1'b0;
                wcnt       = 0;
            end
        end
    end

    // Decode-side monitor: a completed handshake pops the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.o_Valid && bus.i_Ready && !bus.i_DoBranch) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_valid", {31'b0, bus.o_Valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", bus.o_PC, e[63:32]);
                    check("sb_instr", bus.o_Instr, e[31:0]);
                    $display("deliver pc=%h instr=%h", bus.o_PC, bus.o_Instr);
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.i_DoBranch = 1'b0;
        bus.i_BrTarget = '0;
        bus.i_Ready    = 1'b1;

        // Reset values
        step();
        check("rst_ireq", {31'b0, bus.o_IReq}, 32'd0);
        check("rst_valid", {31'b0, bus.o_Valid}, 32'd0);
        check("rst_instr", bus.o_Instr, 32'd0);
        check("rst_pc", bus.o_PC, 32'd0);
        check("rst_misalign", {31'b0, bus.o_Misalign}, 32'd0);
        check("rst_iaddr", bus.o_IAddr, 32'd0);

        // 1: sequential fetch 0,4,8
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        ack_wait = 1;
        rst_n    = 1'b1;
        mem_on   = 1'b1;
        wait_drain("t1_drain");
        mem_on   = 1'b0;
        exp_acks = '{32'h0, 32'h4, 32'h8};
        check_acks("t1_acks");

        // 2: decode stalls for three cycles in OUT
        bus.i_Ready = 1'b0;
        push_exp(32'hC);
        mem_on = 1'b1;
        wait_valid("t2_valid_rise");
        for (int i = 0; i < 4; i++) begin
            check("t2_hold_valid", {31'b0, bus.o_Valid}, 32'd1);
            check("t2_hold_pc", bus.o_PC, 32'hC);
            check("t2_hold_instr", bus.o_Instr, imem(32'hC));
            check("t2_hold_ireq", {31'b0, bus.o_IReq}, 32'd0);
            check("t2_hold_iaddr", bus.o_IAddr, 32'h10);
            if (i < 3) step();
        end
        bus.i_Ready = 1'b1;
        wait_drain("t2_drain");
        mem_on   = 1'b0;
        exp_acks = '{32'hC};
        check_acks("t2_acks");

        // 3: branch to 0x100 while the fetch of 0x10 waits for its ack
        ack_wait       = 3;
        mem_on         = 1'b1;
        bus.i_DoBranch = 1'b1;
        bus.i_BrTarget = 32'h100;
        push_exp(32'h100);
        step();
        bus.i_DoBranch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_addr_held", bus.o_IAddr, 32'h10);
            check("t3_no_valid", {31'b0, bus.o_Valid}, 32'd0);
            step();
        end
        wait_drain("t3_drain");
        mem_on   = 1'b0;
        exp_acks = '{32'h10, 32'h100};
        check_acks("t3_acks");

        // 4: branch to 0x200 in OUT with i_Ready=1 in the same cycle
        ack_wait    = 1;
        bus.i_Ready = 1'b0;
        mem_on      = 1'b1;
        wait_valid("t4_valid_rise");
        check("t4_out_pc", bus.o_PC, 32'h104);
        check("t4_out_ireq", {31'b0, bus.o_IReq}, 32'd0);
        bus.i_Ready    = 1'b1;
        bus.i_DoBranch = 1'b1;
        bus.i_BrTarget = 32'h200;
        push_exp(32'h200);
        step();
        bus.i_DoBranch = 1'b0;
        check("t4_valid_drop", {31'b0, bus.o_Valid}, 32'd0);
        check("t4_iaddr", bus.o_IAddr, 32'h200);
        check("t4_ireq", {31'b0, bus.o_IReq}, 32'd1);
        check("t4_misalign", {31'b0, bus.o_Misalign}, 32'd0);
        wait_drain("t4_drain");
        mem_on   = 1'b0;
        exp_acks = '{32'h104, 32'h200};
        check_acks("t4_acks");

        // 5a: two branches before the ack; the newer target wins
        ack_wait       = 3;
        mem_on         = 1'b1;
        bus.i_DoBranch = 1'b1;
        bus.i_BrTarget = 32'h40;
        step();
        bus.i_BrTarget = 32'h80;
        push_exp(32'h80);
        step();
        bus.i_DoBranch = 1'b0;
        check("t5_addr_held", bus.o_IAddr, 32'h204);
        wait_drain("t5_drain");
        mem_on   = 1'b0;
        exp_acks = '{32'h204, 32'h80};
        check_acks("t5_acks");

        // 5b: misaligned target 0x102 fetches 0x100 with a single misalign pulse
        ack_wait       = 1;
        mem_on         = 1'b1;
        bus.i_DoBranch = 1'b1;
        bus.i_BrTarget = 32'h102;
        push_exp(32'h100);
        step();
        bus.i_DoBranch = 1'b0;
        check("t5_misalign_pulse", {31'b0, bus.o_Misalign}, 32'd1);
        step();
        check("t5_misalign_end", {31'b0, bus.o_Misalign}, 32'd0);
        wait_drain("t5m_drain");
        mem_on   = 1'b0;
        exp_acks = '{32'h84, 32'h100};
        check_acks("t5m_acks");

        // 6: asynchronous reset mid-FETCH, then wrap-around from 0xFFFFFFFC
        check("t6_pre_pc", bus.o_PC, 32'h100);
        rst_n = 1'b0;
        #1;
        check("t6_async_ireq", {31'b0, bus.o_IReq}, 32'd0);
        check("t6_async_valid", {31'b0, bus.o_Valid}, 32'd0);
        check("t6_async_iaddr", bus.o_IAddr, 32'd0);
        check("t6_async_pc", bus.o_PC, 32'd0);
        check("t6_async_instr", bus.o_Instr, 32'd0);
        step();
        bus.i_DoBranch = 1'b1;
        bus.i_BrTarget = 32'h301;
        step();
        bus.i_DoBranch = 1'b0;
        step();
        check("t6_rstbr_iaddr", bus.o_IAddr, 32'd0);
        check("t6_rstbr_misalign", {31'b0, bus.o_Misalign}, 32'd0);
        rst_n = 1'b1;
        step();
        check("t6_ireq_after_rst", {31'b0, bus.o_IReq}, 32'd1);
        check("t6_iaddr_after_rst", bus.o_IAddr, 32'd0);
        mem_on         = 1'b1;
        bus.i_DoBranch = 1'b1;
        bus.i_BrTarget = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        step();
        bus.i_DoBranch = 1'b0;
        wait_drain("t6_drain");
        mem_on   = 1'b0;
        exp_acks = '{32'h0, 32'hFFFF_FFFC, 32'h0};
        check_acks("t6_acks");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
